// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/operand/result handshake bundle for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();
   logic             go;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;
   logic             done;

   modport master (
      output go, a, b,
      input  diff, borrow, busy, done
   );

   modport slave (
      input  go, a, b,
      output diff, borrow, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial a - b, LSB first, through one full-adder cell computing
//            a + ~b + 1 with a registered carry; go/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_sh_r;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_busy;
   logic             r_done;

   logic             w_nb;
   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_result;

   // Full-adder cell on the current LSBs; subtrahend bit inverted, carry seeded to 1.
   assign w_nb     = ~r_sh_b[0];
   assign w_sum    = r_sh_a[0] ^ w_nb ^ r_carry;
   assign w_cout   = (r_sh_a[0] & w_nb) | (r_sh_a[0] & r_carry) | (w_nb & r_carry);
   assign w_result = {w_sum, r_sh_r[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_carry  <= 1'b1;
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_sh_r   <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.go) begin
                  r_sh_a  <= bus.a;
                  r_sh_b  <= bus.b;
                  r_sh_r  <= '0;
                  r_carry <= 1'b1;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_carry <= w_cout;
               r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
               r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
               r_sh_r  <= w_result;
               r_cnt   <= r_cnt + CNT_W'(1);
               // Final bit: publish the full word; no carry out of the MSB means a < b.
               if (r_cnt == c_last_bit) begin
                  r_diff   <= w_result;
                  r_borrow <= ~w_cout;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.diff   = r_diff;
   assign bus.borrow = r_borrow;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   armed = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(4)) if4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=done", name);
   endtask

   // Timing model: phase 0 idle, 1..W running, W+1 the done cycle.
   int         ph8 = 0, ph4 = 0;
   logic [7:0] ca8, cb8, ed8;
   logic [3:0] ca4, cb4, ed4;
   logic       eb8, eb4;

   always @(posedge clk) begin
      if (rst) begin
         ph8 = 0; ed8 = 8'h00; eb8 = 1'b0;
         ph4 = 0; ed4 = 4'h0;  eb4 = 1'b0;
         armed = 1'b1;
      end else begin
         if (ph8 == 0) begin
            if (if8.go) begin ca8 = if8.a; cb8 = if8.b; ph8 = 1; end
         end else if (ph8 < 8) ph8++;
         else if (ph8 == 8) begin
            ed8 = 8'((int'(ca8) - int'(cb8)) % 256);
            eb8 = (ca8 < cb8);
            ph8 = 9;
         end else ph8 = 0;

         if (ph4 == 0) begin
            if (if4.go) begin ca4 = if4.a; cb4 = if4.b; ph4 = 1; end
         end else if (ph4 < 4) ph4++;
         else if (ph4 == 4) begin
            ed4 = 4'((int'(ca4) - int'(cb4) + 16) % 16);
            eb4 = (ca4 < cb4);
            ph4 = 5;
         end else ph4 = 0;
      end
      #1;
      if (armed) begin
         chk("m8_diff",   32'(if8.diff),   32'(ed8));
         chk("m8_borrow", 32'(if8.borrow), 32'(eb8));
         chk("m8_busy",   32'(if8.busy),   32'(ph8 >= 1 && ph8 <= 8));
         chk("m8_done",   32'(if8.done),   32'(ph8 == 9));
         chk("m4_diff",   32'(if4.diff),   32'(ed4));
         chk("m4_borrow", 32'(if4.borrow), 32'(eb4));
         chk("m4_busy",   32'(if4.busy),   32'(ph4 >= 1 && ph4 <= 4));
         chk("m4_done",   32'(if4.done),   32'(ph4 == 5));
      end
   end

   // Directed 8-bit operation with hand-computed expectations and handshake timing.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input string name);
      int k, nbusy;
      @(negedge clk);
      if8.a = a; if8.b = b; if8.go = 1'b1;
      @(negedge clk);
      if8.go = 1'b0;
      nbusy = if8.busy ? 1 : 0;
      k = 0;
      while (!if8.done && k < 40) begin
         @(negedge clk);
         k++;
         if (if8.busy) nbusy++;
      end
      if (!if8.done) fail_now({name, "_timeout"});
      else begin
         chk({name, "_latency"}, 32'(k), 32'd8);
         chk({name, "_busycyc"}, 32'(nbusy), 32'd8);
         chk({name, "_diff"}, 32'(if8.diff), 32'(ed));
         chk({name, "_borrow"}, 32'(if8.borrow), 32'(eb));
         chk({name, "_nobusy"}, 32'(if8.busy), 32'd0);
         @(negedge clk);
         chk({name, "_donepulse"}, 32'(if8.done), 32'd0);
      end
   endtask

   initial begin
      int ndone, first, second, cyc, k;
      if8.go = 1'b0; if8.a = '0; if8.b = '0;
      if4.go = 1'b0; if4.a = '0; if4.b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_diff",   32'(if8.diff),   32'h0);
      chk("rst_borrow", 32'(if8.borrow), 32'h0);
      chk("rst_busy",   32'(if8.busy),   32'h0);
      chk("rst_done",   32'(if8.done),   32'h0);

      op8(8'd200, 8'd55, 8'h91, 1'b0, "c8m37");
      op8(8'd55, 8'd200, 8'h6F, 1'b1, "37mc8");
      op8(8'h00, 8'h01, 8'hFF, 1'b1, "0m1");
      op8(8'hA5, 8'hA5, 8'h00, 1'b0, "eq");

      // go during RUN is ignored
      @(negedge clk); if8.a = 8'hC8; if8.b = 8'h37; if8.go = 1'b1;
      @(negedge clk); if8.go = 1'b0;
      @(negedge clk);
      @(negedge clk); if8.a = 8'h01; if8.b = 8'h01; if8.go = 1'b1;
      @(negedge clk); if8.go = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if8.done) begin
            ndone++;
            chk("ignore_diff", 32'(if8.diff), 32'h91);
         end
      end
      chk("ignore_npulse", 32'(ndone), 32'd1);

      // reset mid-RUN discards the operation
      @(negedge clk); if8.a = 8'h10; if8.b = 8'h01; if8.go = 1'b1;
      @(negedge clk); if8.go = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_busy",   32'(if8.busy),   32'h0);
      chk("midrst_done",   32'(if8.done),   32'h0);
      chk("midrst_diff",   32'(if8.diff),   32'h0);
      chk("midrst_borrow", 32'(if8.borrow), 32'h0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (if8.done) ndone++;
      end
      chk("midrst_nopulse", 32'(ndone), 32'd0);
      op8(8'h40, 8'h41, 8'hFF, 1'b1, "postrst");

      // go held high: back-to-back operations with operands changed after acceptance
      @(negedge clk); if8.a = 8'd10; if8.b = 8'd3; if8.go = 1'b1;
      @(negedge clk); if8.a = 8'd3; if8.b = 8'd10;
      cyc = 1; first = -1; second = -1;
      while (second < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (if8.done) begin
            if (first < 0) begin
               first = cyc;
               chk("held1_diff", 32'(if8.diff), 32'd7);
               chk("held1_borrow", 32'(if8.borrow), 32'd0);
            end else begin
               second = cyc;
               if8.go = 1'b0;
               chk("held2_diff", 32'(if8.diff), 32'hF9);
               chk("held2_borrow", 32'(if8.borrow), 32'd1);
            end
         end else if (first >= 0) begin
            chk("held_stable", 32'(if8.diff), 32'd7);
         end
      end
      if8.go = 1'b0;
      if (second < 0) fail_now("held_timeout");
      else chk("held_gap", 32'(second - first), 32'd10);
      repeat (3) @(negedge clk);

      // Random traffic: operands change every cycle, go toggles, rare resets.
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if8.a  = 8'($urandom);
         if8.b  = 8'($urandom);
         if8.go = ($urandom_range(0, 1) == 1);
         rst    = ($urandom_range(0, 599) == 0);
      end
      if8.go = 1'b0; rst = 1'b0;
      repeat (12) @(negedge clk);

      // Exhaustive 4-bit pairs
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            @(negedge clk); if4.a = 4'(a); if4.b = 4'(b); if4.go = 1'b1;
            @(negedge clk); if4.go = 1'b0;
            k = 0;
            while (!if4.done && k < 20) begin @(negedge clk); k++; end
            if (!if4.done) fail_now("ex4_timeout");
         end
      end
      @(negedge clk); if4.a = 4'h3; if4.b = 4'h9; if4.go = 1'b1;
      @(negedge clk); if4.go = 1'b0;
      k = 0;
      while (!if4.done && k < 20) begin @(negedge clk); k++; end
      if (!if4.done) fail_now("w4_timeout");
      else begin
         chk("w4_latency", 32'(k), 32'd4);
         chk("w4_diff", 32'(if4.diff), 32'hA);
         chk("w4_borrow", 32'(if4.borrow), 32'd1);
      end
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first, through a single full-adder cell with a registered carry (a + ~b + 1). It is the inverse-operation companion to the team's one-full-adder serial adder and uses the same control style: a go-started FSM, a bit counter, and operand/result shift registers. Area-minimal arithmetic unit for the serial datapath, with an explicit busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
go  input  1  start request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted go
b  input  WIDTH  subtrahend; captured on accepted go
diff  output  WIDTH  registered result (a - b) mod 2^WIDTH
borrow  output  1  registered; 1 when a < b unsigned
busy  output  1  1 while in RUN
done  output  1  one-cycle pulse when diff/borrow are updated

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst; all state updates on rising edge of clk.
- Reset: state=IDLE, counter=0, carry=1, shift registers=0, diff=0, borrow=0, busy=0, done=0. rst overrides all other inputs, including mid-RUN; a partial operation is discarded and diff/borrow return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on go=1 at edge E0: load shA<=a, shB<=b, carry<=1, counter<=0, go to RUN. go=0: stay. diff/borrow hold their last values.
- RUN: busy=1. At each edge: s = shA[0] ^ ~shB[0] ^ carry; carry <= majority(shA[0], ~shB[0], carry); shA, shB shift right by 1; s shifts into MSB of result shift register (shR shifts right); counter increments.
- RUN ends after exactly WIDTH bit edges (E1..E_WIDTH). At E_WIDTH: diff <= complete result (including the bit computed on that edge), borrow <= ~carry_out of MSB stage, state -> DONE.
- DONE: done=1, busy=0 for exactly one cycle; at next edge -> IDLE unconditionally.
- Latency: go accepted at E0 -> done high in the cycle following E_WIDTH (WIDTH+1 edges after go). Throughput: one operation per WIDTH+2 cycles.
- go while in RUN or DONE is ignored (not queued). go held high continuously yields back-to-back operations, each re-accepted in IDLE.
- a/b may change freely after the accepting edge; only the captured values are used.
- diff and borrow change only at the DONE-entry edge or reset; stable at all other times.
- Arithmetic: unsigned modulo 2^WIDTH; borrow = 1 iff a < b. Counter width ceil(log2(WIDTH+1)); terminal count compared to WIDTH-1 on the last RUN edge.
- busy and done are never 1 simultaneously; neither is 1 in IDLE.

Test Plan:
- a=200 (0xC8), b=55 (0x37), pulse go -> busy for 8 cycles, done pulse 9 edges after go, diff=0x91 (145), borrow=0.
- a=55, b=200 -> diff=0x6F (111), borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=b=0xA5 -> diff=0x00, borrow=0.
- Start a=0xC8,b=0x37; pulse go again at RUN cycle 3 with a=0x01,b=0x01 -> ignored; result 0x91, exactly one done pulse.
- Start operation, assert rst at RUN cycle 4 -> next edge IDLE, busy=0, done=0, diff=0, borrow=0; no done pulse; new go afterwards yields correct result.
- go held high with a=10,b=3 then a=3,b=10 changed after first acceptance -> two done pulses 10 cycles apart, diff=7/borrow=0 then diff=0xF9/borrow=1; diff stable between pulses.
- Random 1000 pairs (and WIDTH=4 instance exhaustive 256 pairs) -> diff == (a-b) mod 2^WIDTH, borrow == (a<b) against scoreboard.
